if_prefetch_stage: RTL and testbench

//  Next-gen instruction fetch stage with a parametrised prefetch queue.
//  - Fetches sequential instruction words ahead of decode.
//  - Source per address: SPM (1-cycle, always granted) or shared bus (req_/grnt_/rdy_ handshake).
//  - Decouples bus latency from the pipeline.
//  - Redirects on branch or flush, discarding all stale and in-flight fetches.

---
 rtl/if_pkg.sv | 25 ++
 rtl/if_fetch_fifo.sv | 55 +++++
 rtl/if_prefetch_stage.sv | 147 ++++++++++++++
 tb/tb_if_prefetch_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
// Bus FSM states, queue entry layout and strobe/direction encodings.
package if_pkg;

  localparam int IF_ADDR_W = 30;
  localparam int IF_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    DROP
  } if_bus_state_t;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] insn;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch queue of {pc,insn} entries with clear and empty-queue bypass.
// A push into an empty queue that is popped the same cycle never lands in memory.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      push,
  input  if_entry_t din,
  input  logic      pop,
  output if_entry_t dout,
  output logic [PW:0] count,
  output logic      full,
  output logic      empty
);

  if_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic bypass;
  logic do_wr;
  logic do_rd;

  assign empty  = count == '0;
  assign full   = count[PW];
  assign bypass = empty && push && pop;
  assign do_wr  = push && !bypass && (!full || pop);
  assign do_rd  = pop && !empty;
  assign dout   = empty ? din : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage: sequential prefetch from SPM or shared bus
// into a small queue, with branch/flush redirect discarding stale fetches.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W,
  parameter int DEPTH = 4,
  parameter int SPM_TAG_W = 4,
  parameter logic [SPM_TAG_W-1:0] SPM_TAG = '0,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  if_bus_state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] spm_pc;
  logic spm_pend;
  logic as_first;
  logic redirect, in_spm, room, issue;
  logic spm_issue, bus_issue, bus_done, spm_push;
  logic push, pop, full, empty;
  logic [CW-1:0] count;
  if_entry_t din, dout;

  assign redirect  = flush || br_taken;
  assign in_spm    = pc[ADDR_W-1 -: SPM_TAG_W] == SPM_TAG;
  // a returning SPM word still needs a slot, so it counts against room
  assign room      = !full && (count + CW'(spm_pend)) < CW'(DEPTH);
  assign issue     = !rst && !redirect && state == IDLE && room;
  assign spm_issue = issue && in_spm;
  assign bus_issue = issue && !in_spm;
  assign bus_done  = !rst && !redirect && state == ACCESS
                     && bus_rdy_ == ENABLE_;
  assign spm_push  = !rst && !redirect && spm_pend;
  assign push      = spm_push || bus_done;
  assign pop       = !rst && !redirect && !stall && (!empty || push);
  assign din       = spm_push ? '{pc: spm_pc, insn: spm_rd_data}
                              : '{pc: pc, insn: bus_rd_data};

  if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign spm_addr    = pc;
  assign spm_as_     = spm_issue ? ENABLE_ : DISABLE_;
  assign spm_rw      = READ;
  assign spm_wr_data = '0;
  assign bus_addr    = pc;
  assign bus_rw      = READ;
  assign bus_wr_data = '0;
  assign busy        = empty && state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      spm_pc   <= RESET_PC;
      spm_pend <= 1'b0;
      as_first <= 1'b0;
    end else begin
      state    <= state_nx;
      as_first <= state == REQ && state_nx == ACCESS;
      spm_pend <= spm_issue;
      if (spm_issue) spm_pc <= pc;
      if (redirect) pc <= new_pc;
      else if (spm_issue || bus_done) pc <= pc + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    bus_req_ = DISABLE_;
    bus_as_  = DISABLE_;
    unique case (state)
      IDLE: begin
        if (bus_issue) state_nx = REQ;
      end
      REQ: begin
        bus_req_ = redirect ? DISABLE_ : ENABLE_;
        if (redirect) state_nx = IDLE;
        else if (bus_grnt_ == ENABLE_) state_nx = ACCESS;
      end
      ACCESS: begin
        bus_req_ = ENABLE_;
        bus_as_  = as_first ? ENABLE_ : DISABLE_;
        if (bus_rdy_ == ENABLE_) state_nx = IDLE;
        else if (redirect) state_nx = DROP;
      end
      DROP: begin
        bus_req_ = ENABLE_;
        if (bus_rdy_ == ENABLE_) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc   <= RESET_PC;
      if_insn <= '0;
      if_en   <= 1'b0;
    end else if (redirect) begin
      if_en <= 1'b0;
    end else if (!stall) begin
      if_en <= pop;
      if (pop) begin
        if_pc   <= dout.pc;
        if_insn <= dout.insn;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: SPM/bus responders plus an in-order
// instruction stream model; directed scenarios then a random phase.
module tb_if_prefetch_stage;
  import if_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] spm_addr, bus_addr, if_pc, new_pc;
  logic [DW-1:0] spm_wr_data, bus_wr_data, spm_rd_data;
  logic [DW-1:0] bus_rd_data, if_insn;
  logic spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
  logic bus_grnt_, bus_rdy_, stall, flush, br_taken;
  logic if_en, busy;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(4),
    .SPM_TAG_W(4), .SPM_TAG(4'h0), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .stall(stall), .flush(flush), .br_taken(br_taken), .new_pc(new_pc),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en), .busy(busy)
  );

  function automatic logic [DW-1:0] insn_of(input logic [AW-1:0] a);
    return {2'b10, a} ^ 32'h5A5A_5A5A;
  endfunction

  // SPM memory: word for the address presented last cycle
  logic [AW-1:0] spm_lat = '0;
  always @(posedge clk) spm_lat <= spm_addr;
  assign spm_rd_data = insn_of(spm_lat);

  int total = 0;
  int bad = 0;
  int nout = 0;
  logic [AW-1:0] exp_pc = '0;
  logic [AW-1:0] m_pc = '0;
  logic [DW-1:0] m_insn = '0;
  logic m_en = 1'b0;
  bit rst_d = 1'b1, redir_d = 1'b0, stall_d = 1'b0;
  bit saw_as = 1'b0;
  bit racc = 1'b0, gdone = 1'b0, rnd_dly = 1'b0;
  int gcnt = 0, rcnt = 0, gdly = 2, rdly = 3;
  logic [AW-1:0] raddr = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int fixed);
    return rnd_dly ? int'($urandom_range(0, 3)) : fixed;
  endfunction

  task automatic step(input bit s, input bit f, input bit b,
                      input logic [AW-1:0] np, input bit r);
    @(negedge clk);
    saw_as = (bus_as_ == 1'b0);
    if (rst_d) begin
      chk("rst_en", 64'(if_en), 64'(0));
      chk("rst_pc", 64'(if_pc), 64'(0));
      chk("rst_insn", 64'(if_insn), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_strobes", 64'({spm_as_, bus_as_, bus_req_}), 64'(3'b111));
      chk("rst_rw", 64'({spm_rw, bus_rw}), 64'({READ, READ}));
      chk("rst_wdata", 64'({spm_wr_data, bus_wr_data}), 64'(0));
    end else if (redir_d) begin
      chk("redir_en", 64'(if_en), 64'(0));
    end else if (stall_d) begin
      chk("hold_en", 64'(if_en), 64'(m_en));
      chk("hold_pc", 64'(if_pc), 64'(m_pc));
      chk("hold_insn", 64'(if_insn), 64'(m_insn));
    end else if (if_en) begin
      chk("stream_pc", 64'(if_pc), 64'(exp_pc));
      chk("stream_insn", 64'(if_insn), 64'(insn_of(exp_pc)));
      m_pc = exp_pc;
      m_insn = insn_of(exp_pc);
      m_en = 1'b1;
      exp_pc = exp_pc + 1'b1;
      nout++;
    end else begin
      m_en = 1'b0;
    end
    // bus slave: grant after gcnt cycles, ready rcnt cycles after strobe
    bus_grnt_ = 1'b1;
    bus_rdy_ = 1'b1;
    bus_rd_data = $urandom;
    if (!racc && saw_as) begin
      racc = 1'b1;
      raddr = bus_addr;
      rcnt = pick(rdly);
    end
    if (racc) begin
      if (rcnt == 0) begin
        bus_rdy_ = 1'b0;
        bus_rd_data = insn_of(raddr);
        racc = 1'b0;
        gdone = 1'b0;
        gcnt = pick(gdly);
      end else rcnt--;
    end else if (!bus_req_ && !gdone) begin
      if (gcnt == 0) begin
        bus_grnt_ = 1'b0;
        gdone = 1'b1;
      end else gcnt--;
    end else if (bus_req_) begin
      gdone = 1'b0;
      gcnt = pick(gdly);
    end
    stall = s;
    flush = f;
    br_taken = b;
    new_pc = np;
    rst = r;
    rst_d = r;
    redir_d = f || b;
    stall_d = s;
    if (r) begin
      exp_pc = '0;
      m_pc = '0;
      m_insn = '0;
      m_en = 1'b0;
    end else if (f || b) begin
      exp_pc = np;
      m_en = 1'b0;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, AW'($urandom), 1'b0);
  endtask

  task automatic wait_out(input string tag, input int lim, input bit cb);
    int n = nout;
    int k = 0;
    while (nout == n && k < lim) begin
      idle();
      if (cb && saw_as) chk({tag, "_busy"}, 64'(busy), 64'(1));
      k++;
    end
    chk(tag, 64'(nout != n), 64'(1));
  endtask

  task automatic wait_as(input string tag, input int lim);
    int k = 0;
    saw_as = 1'b0;
    while (!saw_as && k < lim) begin
      idle();
      k++;
    end
    chk(tag, 64'(saw_as), 64'(1));
  endtask

  initial begin
    int n;
    bit s, f, b;
    logic [AW-1:0] np;
    stall = 1'b0;
    flush = 1'b0;
    br_taken = 1'b0;
    new_pc = '0;
    bus_grnt_ = 1'b1;
    bus_rdy_ = 1'b1;
    bus_rd_data = '0;

    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    // reset release: fetch of pc 0 issues right away from SPM
    idle();
    #1;
    chk("t1_issue_as", 64'(spm_as_), 64'(0));
    chk("t1_issue_addr", 64'(spm_addr), 64'(0));
    n = nout;
    idle();
    chk("t1_c1_en", 64'(if_en), 64'(0));
    idle();
    chk("t1_c2_en", 64'(if_en), 64'(1));
    chk("t1_c2_pc", 64'(if_pc), 64'(0));
    repeat (3) idle();
    chk("t1_every_cycle", 64'(nout - n), 64'(4));

    // stall fills the queue, fetching stops, then resumes in order
    repeat (6) step(1'b1, 1'b0, 1'b0, AW'($urandom), 1'b0);
    chk("t2_full_no_issue", 64'(spm_as_), 64'(1));
    chk("t2_busy", 64'(busy), 64'(0));
    n = nout;
    repeat (8) idle();
    chk("t2_resume", 64'(nout - n >= 6), 64'(1));

    // bus fetch with grant after 2, ready after 3
    gdly = 2;
    rdly = 3;
    step(1'b0, 1'b0, 1'b1, 30'h1000_0000, 1'b0);
    wait_out("t3_bus_out", 30, 1'b1);
    chk("t3_pc", 64'(if_pc), 64'(30'h1000_0000));
    chk("t3_insn", 64'(if_insn), 64'(insn_of(30'h1000_0000)));

    // branch during ACCESS: stale word dropped
    step(1'b0, 1'b0, 1'b1, 30'h1000_0100, 1'b0);
    wait_as("t4_as", 30);
    step(1'b0, 1'b0, 1'b1, 30'h40, 1'b0);
    wait_out("t4_out", 30, 1'b0);
    chk("t4_pc", 64'(if_pc), 64'(30'h40));
    repeat (3) idle();

    // flush and branch together
    step(1'b0, 1'b1, 1'b1, 30'h80, 1'b0);
    idle();
    chk("t5_en", 64'(if_en), 64'(0));
    wait_out("t5_out", 30, 1'b0);
    chk("t5_pc", 64'(if_pc), 64'(30'h80));

    // fetch pc wraps from all-ones to zero
    gdly = 1;
    rdly = 1;
    step(1'b0, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b0);
    wait_out("t6_top", 30, 1'b0);
    chk("t6_top_pc", 64'(if_pc), 64'(30'h3FFF_FFFF));
    wait_out("t6_wrap", 30, 1'b0);
    chk("t6_wrap_pc", 64'(if_pc), 64'(0));

    // reset mid-access, late ready must be ignored
    rdly = 4;
    step(1'b0, 1'b0, 1'b1, 30'h1000_0200, 1'b0);
    wait_as("t6_as", 30);
    step(1'b0, 1'b0, 1'b0, AW'($urandom), 1'b1);
    idle();
    chk("t6_rst_en", 64'(if_en), 64'(0));
    wait_out("t6_after_rst", 30, 1'b0);
    chk("t6_after_rst_pc", 64'(if_pc), 64'(0));
    n = nout;
    repeat (10) idle();
    chk("t6_stream", 64'(nout - n), 64'(10));

    // random stall / redirect / bus timing
    rnd_dly = 1'b1;
    n = nout;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) np = {4'h1, 26'($urandom)};
      else np = {4'h0, 26'($urandom)};
      step(s, f, b, np, 1'b0);
    end
    chk("rand_progress", 64'(nout - n > 100), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
